// File: rtl/rr_packet_arbiter_if.sv
// Bundle of requester-side and sink-side handshake signals for the round-robin packet arbiter.
interface rr_packet_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [IDX_WIDTH-1:0]          out_idx;
    logic                          out_last;
    logic                          out_ready;
    logic                          busy;

    // Arbiter side: consumes requests, produces the registered output beat.
    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_idx, out_last, busy
    );

    // Environment side: drives requests and the sink ready.
    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter with packet locking feeding a single registered output stage.
module rr_packet_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 2
) (
    input  logic               clk,
    input  logic               reset,
    rr_packet_arbiter_if.slave bus
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_WIDTH-1:0]    r_rr_ptr;
    logic [IDX_WIDTH-1:0]    r_owner;
    logic [IDX_WIDTH-1:0]    w_winner;
    logic [IDX_WIDTH-1:0]    w_scan;
    logic [IDX_WIDTH-1:0]    w_sel;
    logic                    w_found;
    logic                    w_accept;
    logic                    w_xfer;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [NUM_REQ-1:0]      w_ready;

    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [IDX_WIDTH-1:0]    r_out_idx;
    logic                    r_out_last;

    // Output register may load when empty or being drained this cycle.
    assign w_accept = !r_out_valid || bus.out_ready;

    // First valid requester at or after the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (32'(r_rr_ptr) + k >= NUM_REQ) begin
                w_scan = IDX_WIDTH'(32'(r_rr_ptr) + k - NUM_REQ);
            end else begin
                w_scan = IDX_WIDTH'(32'(r_rr_ptr) + k);
            end
            if (!w_found && bus.req_valid[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: lock on a non-last beat from IDLE, release on the owner's last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !w_sel_last) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_xfer && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // FSM outputs: one-hot ready toward the round-robin winner or the lock owner.
    always_comb begin
        w_ready = '0;
        w_sel   = w_winner;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_found) begin
                    w_ready[w_winner] = 1'b1;
                end
            end
            ST_LOCKED: begin
                w_sel = r_owner;
                if (w_accept && bus.req_valid[r_owner]) begin
                    w_ready[r_owner] = 1'b1;
                end
            end
        endcase
    end

    assign w_xfer     = |w_ready;
    assign w_sel_last = bus.req_last[w_sel];
    assign w_sel_data = bus.req_data[32'(w_sel)*DATA_WIDTH +: DATA_WIDTH];

    // Pointer advances past each winner granted from IDLE; owner latched when a packet locks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else if (r_state == ST_IDLE && w_xfer) begin
            r_rr_ptr <= (32'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + IDX_WIDTH'(1);
            if (!w_sel_last) begin
                r_owner <= w_winner;
            end
        end
    end

    // Output stage: load on transfer, empty when accepting with nothing to take.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_idx   <= w_sel;
            r_out_last  <= w_sel_last;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Randomized and directed bench for rr_packet_arbiter against a transaction-level model.
module tb_rr_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rr_packet_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    rr_packet_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arbitration pointer, lock owner (-1 = none), output register.
    int          m_ptr;
    int          m_owner;
    logic        m_ov;
    logic [7:0]  m_od;
    int          m_oi;
    logic        m_ol;
    int          last_grant;

    // Stimulus state per requester.
    logic        s_valid [N];
    logic [7:0]  s_data  [N];
    logic        s_last  [N];
    int          s_rem   [N];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_ov = 1'b0; m_od = 8'h00; m_oi = 0; m_ol = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_busy",      32'(bus.busy),      32'd0);
        check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("rst_out_idx",   32'(bus.out_idx),   32'd0);
        check_eq("rst_out_last",  32'(bus.out_last),  32'd0);
    endtask

    // Apply one cycle of inputs, compare DUT to the model, then advance the model.
    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                         input logic [N-1:0] l, input logic ordy);
        int   g;
        logic acc;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.out_ready = ordy;
        #1;
        g   = -1;
        acc = !m_ov || ordy;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            if (!acc) g = -1;
        end else if (acc && v[m_owner]) begin
            g = m_owner;
        end
        check_eq("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check_eq("busy",      32'(bus.busy),      32'(m_owner >= 0));
        check_eq("out_data",  32'(bus.out_data),  32'(m_od));
        check_eq("out_idx",   32'(bus.out_idx),   32'(m_oi));
        check_eq("out_last",  32'(bus.out_last),  32'(m_ol));
        if (g >= 0) begin
            m_ov = 1'b1;
            m_od = d[g*DW +: DW];
            m_oi = g;
            m_ol = l[g];
            if (m_owner < 0) begin
                m_ptr = (g + 1) % N;
                if (!l[g]) m_owner = g;
            end else if (l[g]) begin
                m_owner = -1;
            end
        end else if (acc) begin
            m_ov = 1'b0;
        end
        last_grant = g;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            s_valid[i] = 1'b0; s_data[i] = 8'h00; s_last[i] = 1'b0; s_rem[i] = 0;
        end
    endtask

    initial begin
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        logic [N-1:0]    l;
        logic            ordy;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b0;
        model_reset();
        clear_stim();

        // Single beat from requester 0.
        apply_reset();
        drive(4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5}, 4'b0001, 1'b1);
        check_eq("t1_ready", 32'(bus.req_ready), 32'h1);
        drive(4'b0000, '0, 4'b0000, 1'b1);
        check_eq("t1_data", 32'(bus.out_data), 32'hA5);

        // All requesters valid, single-beat packets, rotating one per cycle.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(4'hF, {8'h33, 8'h22, 8'h11, 8'h00}, 4'hF, 1'b1);
            check_eq("t2_ready", 32'(bus.req_ready), 32'd1 << (i % 4));
            if (i > 0) check_eq("t2_idx", 32'(bus.out_idx), 32'((i - 1) % 4));
        end

        // Three-beat packet from requester 1 holds off requester 2.
        apply_reset();
        drive(4'b0110, {8'h00, 8'h20, 8'h10, 8'h00}, 4'b0100, 1'b1);
        check_eq("t3_ready0", 32'(bus.req_ready), 32'h2);
        drive(4'b0110, {8'h00, 8'h20, 8'h11, 8'h00}, 4'b0100, 1'b1);
        check_eq("t3_ready1", 32'(bus.req_ready), 32'h2);
        check_eq("t3_busy1",  32'(bus.busy), 32'd1);
        drive(4'b0110, {8'h00, 8'h20, 8'h12, 8'h00}, 4'b0110, 1'b1);
        check_eq("t3_ready2", 32'(bus.req_ready), 32'h2);
        drive(4'b0100, {8'h00, 8'h20, 8'h00, 8'h00}, 4'b0100, 1'b1);
        check_eq("t3_busy_end", 32'(bus.busy), 32'd0);
        check_eq("t3_data12",   32'(bus.out_data), 32'h12);
        drive(4'b0000, '0, 4'b0000, 1'b1);
        check_eq("t3_idx2", 32'(bus.out_idx), 32'd2);

        // Backpressure holds the output and blocks all requesters.
        apply_reset();
        drive(4'hF, {8'hB3, 8'hB2, 8'hB1, 8'hB0}, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, {8'hB3, 8'hB2, 8'hB1, 8'hB0}, 4'hF, 1'b0);
            check_eq("t4_ready", 32'(bus.req_ready), 32'h0);
            check_eq("t4_hold",  32'(bus.out_data), 32'hB0);
        end
        drive(4'hF, {8'hB3, 8'hB2, 8'hB1, 8'hB0}, 4'hF, 1'b1);
        check_eq("t4_resume", 32'(bus.req_ready), 32'h2);

        // Pointer wrap from requester 3 back to 0.
        apply_reset();
        drive(4'b0100, {8'h43, 8'h42, 8'h41, 8'h40}, 4'hF, 1'b1);
        drive(4'b1001, {8'h43, 8'h42, 8'h41, 8'h40}, 4'hF, 1'b1);
        check_eq("t5_ready3", 32'(bus.req_ready), 32'h8);
        drive(4'b1001, {8'h53, 8'h42, 8'h41, 8'h40}, 4'hF, 1'b1);
        check_eq("t5_ready0", 32'(bus.req_ready), 32'h1);

        // Reset in the middle of a locked packet.
        apply_reset();
        drive(4'b1000, {8'h30, 8'h00, 8'h00, 8'h00}, 4'b0000, 1'b1);
        apply_reset();
        drive(4'b1001, {8'h31, 8'h00, 8'h00, 8'h07}, 4'b1001, 1'b1);
        check_eq("t6_ready0", 32'(bus.req_ready), 32'h1);

        // Random traffic with packets of 1..4 beats, gaps and backpressure.
        apply_reset();
        clear_stim();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                apply_reset();
                clear_stim();
            end
            for (int i = 0; i < N; i++) begin
                if (!s_valid[i]) begin
                    if (s_rem[i] == 0 && ($urandom % 2) == 0) s_rem[i] = 1 + int'($urandom % 4);
                    if (s_rem[i] > 0 && ($urandom % 3) != 0) begin
                        s_valid[i] = 1'b1;
                        s_data[i]  = 8'($urandom);
                        s_last[i]  = (s_rem[i] == 1);
                    end
                end
                v[i]          = s_valid[i];
                d[i*DW +: DW] = s_data[i];
                l[i]          = s_last[i];
            end
            ordy = ($urandom % 4) != 0;
            drive(v, d, l, ordy);
            if (last_grant >= 0) begin
                s_valid[last_grant] = 1'b0;
                s_rem[last_grant]   = s_rem[last_grant] - 1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
Round-robin arbiter that shares one registered output channel between NUM_REQ requesters using valid/ready handshakes. It supports multi-beat packets: once a requester wins, it keeps the grant until its last beat transfers. The output stage is a single register, built the same way as our other registered primitives. It sits in front of any shared sink, such as a register bank write port or a downstream FIFO.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, payload width per beat
IDX_WIDTH, 2, width of the requester index; must equal clog2(NUM_REQ)

Ports:
clk  input  1  rising-edge clock for all state
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  per-requester end-of-packet flag for the current beat
req_ready  output  NUM_REQ  per-requester beat accepted this cycle (combinational)
out_valid  output  1  registered output beat valid
out_data  output  DATA_WIDTH  registered output payload
out_idx  output  IDX_WIDTH  index of the requester that sourced the output beat
out_last  output  1  registered end-of-packet flag
out_ready  input  1  sink accepts the output beat
busy  output  1  high while a multi-beat packet holds the grant

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. Internal reset values: rr_ptr=0, state=IDLE, owner=0.
- Reset mid-packet: the lock is abandoned and any held output beat is dropped.
- Accept condition: accept = !out_valid || out_ready. The output register loads only when accept=1.
- Transfer on input i: req_valid[i] && req_ready[i].
- Handshake rules (requesters): valid must not depend on ready. Once valid is high, req_data and req_last must stay stable until the beat transfers.
- Handshake rules (arbiter): req_ready may depend on req_valid. At most one req_ready bit is high in any cycle.
- Latency: a beat transferring in cycle N appears on out_* in cycle N+1. Throughput is 1 beat/cycle while out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0, out_* hold their values and all req_ready bits are 0.
- State machine, IDLE:
  - winner = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NUM_REQ-1 to 0.
  - If accept=1 and a winner exists: req_ready[winner]=1 and the beat transfers.
  - On that transfer: rr_ptr <= (winner+1) mod NUM_REQ.
  - If req_last[winner]=0: owner <= winner and go to LOCKED. If req_last[winner]=1: stay in IDLE.
- State machine, LOCKED:
  - req_ready[owner] = accept && req_valid[owner]. All other req_ready bits are 0.
  - Gaps where req_valid[owner]=0 are allowed; the lock is kept through them.
  - When a beat transfers with req_last[owner]=1: go to IDLE.
  - rr_ptr does not change while in LOCKED.
- busy = (state==LOCKED).
- Output register on each transfer: out_data, out_idx and out_last load from the granted requester, and out_valid <= 1.
- Output register with accept=1 and no transfer: out_valid <= 0. out_data, out_idx and out_last keep their last values.
- Simultaneous events: output draining (out_ready=1) and a new beat transferring in the same cycle is the normal back-to-back case; there is no bubble.
- Index width: out_idx is IDX_WIDTH bits. The rr_ptr increment wraps modulo NUM_REQ, including when NUM_REQ is not a power of two.

Test Plan:
1. After reset, req_valid=4'b0001, req_data[0]=8'hA5, req_last[0]=1, out_ready=1 -> req_ready=4'b0001 in the same cycle. Next cycle: out_valid=1, out_data=8'hA5, out_idx=0, out_last=1.
2. All four requesters valid with single-beat packets, out_ready=1 constantly -> out_idx sequence 0,1,2,3,0,1, one beat per cycle with no bubbles.
3. Requester 1 sends a 3-beat packet (8'h10, 8'h11, 8'h12 with last on the third) while requester 2 is continuously valid -> req_ready[2]=0 and busy=1 for the first two beats. Output sequence is idx1 10,11,12, then idx2. busy returns to 0 after the last beat transfers.
4. Backpressure: out_valid=1, out_ready=0 for 3 cycles with all requesters valid -> all req_ready=0 and out_data unchanged. Releasing out_ready -> transfers resume in the next round-robin order.
5. Wrap: after a grant to requester 2 (rr_ptr=3), req_valid=4'b1001 -> requester 3 wins, then requester 0.
6. Reset mid-packet: requester 3 sends beat 1 of a 3-beat packet, then reset is asserted for one cycle -> out_valid=0 and busy=0. With req_valid=4'b1001 afterwards, requester 0 is granted first.
